sha3_squeeze_ctrl: RTL

SHA3_SQUEEZE_CTRL -- requirements
Module: sha3_squeeze_ctrl

---
 rtl/sha3_pkg.sv | 10 +
 rtl/sha3_squeeze_ctrl_if.sv | 25 ++
 rtl/countern.sv | 13 +
 rtl/sha3_squeeze_ctrl.sv | 55 +++++
 4 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared state encoding, SHAKE rate constants and ceiling-divide helper
package sha3_pkg;
  typedef enum logic [1:0] {IDLE, SQUEEZE, PERM_WAIT} state_t;
  localparam int SHAKE128_RATE_WORDS = 21;
  localparam int SHAKE256_RATE_WORDS = 17;
  localparam int DEFAULT_W = 64;
  function automatic int unsigned divceil(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/sha3_squeeze_ctrl_if.sv
// sha3_squeeze_ctrl_if: host/destination/permutation handshake bundle for the squeeze controller
//   master: host side (drives start, size, dst_ready, perm_done, abort)
//   slave:  controller side (drives acks, write strobes, mask, perm_req)
interface sha3_squeeze_ctrl_if import sha3_pkg::*; #(parameter int W = DEFAULT_W, parameter int LEN_W = 16) ();
  logic output_write;
  logic [LEN_W-1:0] output_size;
  logic output_write_clr;
  logic output_busy_clr;
  logic dst_ready;
  logic dst_write;
  logic eo;
  logic last_out_word;
  logic [W/8-1:0] last_byte_mask;
  logic perm_req;
  logic perm_done;
  logic abort;
  modport master(
    output output_write, output_size, dst_ready, perm_done, abort,
    input output_write_clr, output_busy_clr, dst_write, eo, last_out_word, last_byte_mask, perm_req
  );
  modport slave(
    input output_write, output_size, dst_ready, perm_done, abort,
    output output_write_clr, output_busy_clr, dst_write, eo, last_out_word, last_byte_mask, perm_req
  );
endinterface

// File: rtl/countern.sv
// countern: N-bit loadable counter, counts up (or down when DOWN=1) on en
//   clk, rst (sync active-low), load/d (parallel load, has priority), en, q
module countern #(parameter int N = 8, parameter bit DOWN = 1'b0) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    q <= !rst ? '0 : load ? d : en ? (DOWN ? q - 1'b1 : q + 1'b1) : q;
endmodule

// File: rtl/sha3_squeeze_ctrl.sv
// sha3_squeeze_ctrl: sequences SHAKE output words to a destination, requesting permutations between rate blocks
//   clk, rst (sync active-low), bus (slave modport: start/ack, dst handshake, byte mask, perm handshake, abort)
module sha3_squeeze_ctrl import sha3_pkg::*; #(
  parameter int W = DEFAULT_W,
  parameter int RATE_WORDS = SHAKE128_RATE_WORDS,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic rst,
  sha3_squeeze_ctrl_if.slave bus
);
  localparam int B = W / 8;
  localparam int BW = $clog2(B);
  localparam int RCW = $clog2(RATE_WORDS) + 1;
  state_t state, next;
  logic [LEN_W:0] words;
  logic [RCW-1:0] rc;
  logic [BW-1:0] tail;
  logic start, last, wr, perm_ack, active;
  assign active = state == SQUEEZE || state == PERM_WAIT;
  assign start = rst && state == IDLE && bus.output_write;
  assign last = state == SQUEEZE && words == (LEN_W+1)'(1);
  // abort wins over a pending transfer so an aborted job never emits a word
  assign wr = rst && state == SQUEEZE && bus.dst_ready && !bus.abort;
  assign perm_ack = rst && state == PERM_WAIT && bus.perm_done && !bus.abort;
  countern #(.N(LEN_W + 1), .DOWN(1'b1)) u_words (
    .clk(clk), .rst(rst), .load(start), .en(wr),
    .d((LEN_W+1)'(divceil(32'(bus.output_size), B))), .q(words)
  );
  countern #(.N(RCW)) u_rc (
    .clk(clk), .rst(rst), .load(start || perm_ack), .en(wr), .d('0), .q(rc)
  );
  always_ff @(posedge clk) begin
    state <= rst ? next : IDLE;
    tail <= !rst ? '0 : start ? bus.output_size[BW-1:0] : tail;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.output_write && bus.output_size != '0 ? SQUEEZE : IDLE;
      SQUEEZE: next = bus.abort || (bus.dst_ready && last) ? IDLE :
                      bus.dst_ready && rc == RCW'(RATE_WORDS - 1) ? PERM_WAIT : SQUEEZE;
      PERM_WAIT: next = bus.abort ? IDLE : bus.perm_done ? SQUEEZE : PERM_WAIT;
      default: next = IDLE;
    endcase
    bus.output_write_clr = start;
    // abort suppresses wr, so an abort on the last word yields a single pulse
    bus.output_busy_clr = rst && ((start && bus.output_size == '0) || (active && bus.abort) || (wr && last));
    bus.dst_write = wr;
    bus.eo = wr;
    bus.last_out_word = rst && last;
    bus.perm_req = rst && state == PERM_WAIT;
    bus.last_byte_mask = !rst ? '0 : last && tail != '0 ? ~({B{1'b1}} << tail) : '1;
  end
endmodule
